// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
// Memory-mapped 4-digit multiplexed seven-segment display controller.
// Software writes a DATA register (four hex nibbles plus four decimal
// points) and a CTRL register (ENABLE, LZ_BLANK). The scanner drives one
// digit at a time for SCAN_DIV clocks, with registered, glitch-free
// active-low anode and cathode outputs.
// Optional feature: define SSEG_GHOST_BLANK_EN to insert BLANK_CYC
// all-off cycles between digit slots to suppress ghosting.
module seven_seg_scan_ctrl #(
  parameter int          SCAN_DIV  = 25000,
  parameter int          BLANK_CYC = 500,
  parameter logic [31:0] DATA_ADDR = 32'h1100C010,
  parameter logic [31:0] CTRL_ADDR = 32'h1100C014
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_in,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  // One counter serves both the SHOW and BLANK dwell times.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
`ifdef SSEG_GHOST_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHOW  = 2'd1,
    S_BLANK = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [1:0]       idx_nxt_s;
  logic [3:0]       an_q;
  logic [7:0]       segs_q;
  logic [19:0]      data_q;
  logic [19:0]      data_d;
  logic [1:0]       ctrl_q;
  logic [1:0]       ctrl_d;
  logic             enable_s;
  logic             lz_blank_s;
  logic             unused_s;

  assign enable_s   = ctrl_q[0];
  assign lz_blank_s = ctrl_q[1];
  assign idx_nxt_s  = idx_q + 2'd1;
  assign unused_s   = ^iobus_out[31:20];

  // Hex nibble to active-low a..g pattern (bit0 = a, bit6 = g).
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b100_0000;
      4'h1:    seg = 7'b111_1001;
      4'h2:    seg = 7'b010_0100;
      4'h3:    seg = 7'b011_0000;
      4'h4:    seg = 7'b001_1001;
      4'h5:    seg = 7'b001_0010;
      4'h6:    seg = 7'b000_0010;
      4'h7:    seg = 7'b111_1000;
      4'h8:    seg = 7'b000_0000;
      4'h9:    seg = 7'b001_0000;
      4'hA:    seg = 7'b000_1000;
      4'hB:    seg = 7'b000_0011;
      4'hC:    seg = 7'b100_0110;
      4'hD:    seg = 7'b010_0001;
      4'hE:    seg = 7'b000_0110;
      4'hF:    seg = 7'b000_1110;
      default: seg = 7'b111_1111;
    endcase
    return seg;
  endfunction

  // Anode/cathode image {an, segs} for digit idx, captured at slot entry.
  // With leading-zero blanking, a digit is dark when it and every higher
  // digit are zero; digit 0 is always shown.
  function automatic logic [11:0] slot_image(input logic [19:0] data,
                                             input logic        lz,
                                             input logic [1:0]  idx);
    logic [3:0] nib;
    logic       dp;
    logic       blank;
    logic [3:0] an_sel;
    case (idx)
      2'd0: begin
        nib = data[3:0];   dp = data[16]; blank = 1'b0;
        an_sel = 4'b1110;
      end
      2'd1: begin
        nib = data[7:4];   dp = data[17]; blank = lz && (data[15:4] == 12'h000);
        an_sel = 4'b1101;
      end
      2'd2: begin
        nib = data[11:8];  dp = data[18]; blank = lz && (data[15:8] == 8'h00);
        an_sel = 4'b1011;
      end
      2'd3: begin
        nib = data[15:12]; dp = data[19]; blank = lz && (data[15:12] == 4'h0);
        an_sel = 4'b0111;
      end
      default: begin
        nib = 4'h0; dp = 1'b0; blank = 1'b1;
        an_sel = 4'b1111;
      end
    endcase
    if (blank) begin
      return {4'hF, 8'hFF};
    end else begin
      return {an_sel, ~dp, hex_to_seg(nib)};
    end
  endfunction

  // Register write decode: only the addressed register's defined bits change.
  always_comb begin
    data_d = data_q;
    ctrl_d = ctrl_q;
    if (iobus_wr && (iobus_addr == DATA_ADDR)) begin
      data_d = iobus_out[19:0];
    end else begin
      data_d = data_q;
    end
    if (iobus_wr && (iobus_addr == CTRL_ADDR)) begin
      ctrl_d = iobus_out[1:0];
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // DATA and CTRL storage.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= 20'h0_0000;
      ctrl_q <= 2'b00;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
    end
  end

  // Combinational readback; zero for any unmapped address.
  always_comb begin
    iobus_in = 32'h0000_0000;
    if (iobus_addr == DATA_ADDR) begin
      iobus_in = {12'h000, data_q};
    end else if (iobus_addr == CTRL_ADDR) begin
      iobus_in = {30'h0000_0000, ctrl_q};
    end else begin
      iobus_in = 32'h0000_0000;
    end
  end

  // Scan FSM with registered outputs; slot images use pre-write register values.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 2'd0;
      an_q    <= 4'hF;
      segs_q  <= 8'hFF;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= CNT_ZERO;
          idx_q <= 2'd0;
          if (enable_s) begin
            state_q         <= S_SHOW;
            {an_q, segs_q}  <= slot_image(data_q, lz_blank_s, 2'd0);
          end else begin
            state_q <= S_IDLE;
            an_q    <= 4'hF;
            segs_q  <= 8'hFF;
          end
        end

        S_SHOW: begin
          if (!enable_s) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 2'd0;
            an_q    <= 4'hF;
            segs_q  <= 8'hFF;
          end else if (cnt_q == SCAN_LAST) begin
            cnt_q <= CNT_ZERO;
            idx_q <= idx_nxt_s;
`ifdef SSEG_GHOST_BLANK_EN
            state_q <= S_BLANK;
            an_q    <= 4'hF;
            segs_q  <= 8'hFF;
`else
            state_q         <= S_SHOW;
            {an_q, segs_q}  <= slot_image(data_q, lz_blank_s, idx_nxt_s);
`endif
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_BLANK: begin
`ifdef SSEG_GHOST_BLANK_EN
          if (!enable_s) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 2'd0;
            an_q    <= 4'hF;
            segs_q  <= 8'hFF;
          end else if (cnt_q == BLANK_LAST) begin
            state_q         <= S_SHOW;
            cnt_q           <= CNT_ZERO;
            {an_q, segs_q}  <= slot_image(data_q, lz_blank_s, idx_q);
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
`else
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          idx_q   <= 2'd0;
          an_q    <= 4'hF;
          segs_q  <= 8'hFF;
`endif
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= CNT_ZERO;
          idx_q   <= 2'd0;
          an_q    <= 4'hF;
          segs_q  <= 8'hFF;
        end
      endcase
    end
  end

  assign an   = an_q;
  assign segs = segs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Testbench for seven_seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=2).
// Reference model: a cycle-time view of the display -- time since scanning
// started, divided into per-digit periods, with the register contents
// snapshotted at the start of each period.
`timescale 1ns/1ps
module tb_seven_seg_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;
`ifdef SSEG_GHOST_BLANK_EN
  localparam int PERIOD = SCAN_DIV + BLANK_CYC;
`else
  localparam int PERIOD = SCAN_DIV;
`endif
  localparam logic [31:0] DATA_ADDR = 32'h1100C010;
  localparam logic [31:0] CTRL_ADDR = 32'h1100C014;

  logic        clk = 1'b0;
  logic        RST_N;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] iobus_in;
  logic [7:0]  segs;
  logic [3:0]  an;

  int n_cmp = 0;
  int n_bad = 0;

  seven_seg_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC),
    .DATA_ADDR(DATA_ADDR),
    .CTRL_ADDR(CTRL_ADDR)
  ) dut (
    .clk       (clk),
    .RST_N     (RST_N),
    .iobus_addr(iobus_addr),
    .iobus_out (iobus_out),
    .iobus_wr  (iobus_wr),
    .iobus_in  (iobus_in),
    .segs      (segs),
    .an        (an)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic        m_run;
  int          m_t;
  logic [19:0] m_data;
  logic [1:0]  m_ctrl;
  logic [19:0] snap_data;
  logic        snap_lz;

  always @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      m_run <= 1'b0; m_t <= 0; m_data <= 20'h0; m_ctrl <= 2'b00;
      snap_data <= 20'h0; snap_lz <= 1'b0;
    end else begin
      if (!m_run) begin
        if (m_ctrl[0]) begin
          m_run <= 1'b1; m_t <= 0; snap_data <= m_data; snap_lz <= m_ctrl[1];
        end
      end else if (!m_ctrl[0]) begin
        m_run <= 1'b0;
      end else begin
        m_t <= m_t + 1;
        if (((m_t + 1) % PERIOD) == 0) begin
          snap_data <= m_data; snap_lz <= m_ctrl[1];
        end
      end
      if (iobus_wr && iobus_addr == DATA_ADDR) m_data <= iobus_out[19:0];
      if (iobus_wr && iobus_addr == CTRL_ADDR) m_ctrl <= iobus_out[1:0];
    end
  end

  function automatic logic [7:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
      4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
      4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
      4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
    endcase
  endfunction

  function automatic logic [11:0] model_out(input logic run, input int t,
                                            input logic [19:0] d, input logic lz);
    int         dig;
    logic       upper_zero;
    logic [7:0] g;
    logic [3:0] sel;
    if (!run) return 12'hFFF;
    if ((t % PERIOD) >= SCAN_DIV) return 12'hFFF;
    dig = (t / PERIOD) % 4;
    upper_zero = 1'b1;
    for (int j = dig; j < 4; j++) if (d[4*j +: 4] != 4'h0) upper_zero = 1'b0;
    if (lz && dig > 0 && upper_zero) return 12'hFFF;
    g = glyph(d[4*dig +: 4]);
    if (d[16+dig]) g[7] = 1'b0;
    sel = 4'hF;
    sel[dig] = 1'b0;
    return {sel, g};
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == DATA_ADDR) return {12'h0, m_data};
    if (a == CTRL_ADDR) return {30'h0, m_ctrl};
    return 32'h0;
  endfunction

  // Called at a negedge; drives one write cycle and returns at the next negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    iobus_addr = a; iobus_out = d; iobus_wr = 1'b1;
    @(negedge clk);
    iobus_wr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST_N = 1'b0; iobus_wr = 1'b0; iobus_addr = DATA_ADDR; iobus_out = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      n_bad++; $display("FAIL reset_out: an=%h segs=%h expected F/FF", an, segs);
    end
    n_cmp++;
    if (iobus_in !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_rd: got %h expected 0", iobus_in);
    end
    RST_N = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || segs !== 8'hFF) begin
        n_bad++; $display("FAIL reset_idle: an=%h segs=%h expected F/FF", an, segs);
      end
    end
  endtask

  task automatic test_basic_scan();
    logic [11:0] e;
    bus_write(DATA_ADDR, 32'h0000_1234);
    bus_write(CTRL_ADDR, 32'h0000_0001);
    iobus_addr = DATA_ADDR; #1;
    n_cmp++;
    if (iobus_in !== 32'h0000_1234) begin
      n_bad++; $display("FAIL basic_rd_data: got %h expected 00001234", iobus_in);
    end
    iobus_addr = CTRL_ADDR; #1;
    n_cmp++;
    if (iobus_in !== 32'h1) begin
      n_bad++; $display("FAIL basic_rd_ctrl: got %h expected 1", iobus_in);
    end
    iobus_addr = 32'h1100C018; #1;
    n_cmp++;
    if (iobus_in !== 32'h0) begin
      n_bad++; $display("FAIL basic_rd_other: got %h expected 0", iobus_in);
    end
    repeat (5 * PERIOD) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e) begin
        n_bad++; $display("FAIL basic_scan: an/segs=%h/%h expected %h/%h", an, segs, e[11:8], e[7:0]);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [11:0] e;
    bus_write(DATA_ADDR, 32'h0000_0007);
    bus_write(CTRL_ADDR, 32'h0000_0003);
    repeat (PERIOD) @(negedge clk);
    repeat (6 * PERIOD) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e) begin
        n_bad++; $display("FAIL lz_scan: an/segs=%h/%h expected %h/%h", an, segs, e[11:8], e[7:0]);
      end
      n_cmp++;
      if (an[3:1] !== 3'b111 || (an[0] === 1'b0 && segs !== 8'hF8)
          || (an[0] === 1'b1 && segs !== 8'hFF)) begin
        n_bad++; $display("FAIL lz_only_digit0: an=%b segs=%h", an, segs);
      end
    end
  endtask

  task automatic test_midslot_write();
    logic [11:0] e;
    int k;
    bus_write(CTRL_ADDR, 32'h0000_0001);
    bus_write(DATA_ADDR, 32'h0000_1234);
    k = 0;
    while (an !== 4'b1101 && k < 60) begin @(negedge clk); k++; end
    n_cmp++;
    if (an !== 4'b1101) begin
      n_bad++; $display("FAIL midslot_wait: an=%b never reached 1101", an);
    end
    bus_write(DATA_ADDR, 32'h000F_ABCD);
    n_cmp++;
    if (an !== 4'b1101 || segs !== 8'hB0) begin
      n_bad++; $display("FAIL midslot_hold: an/segs=%b/%h expected 1101/B0", an, segs);
    end
    repeat (6 * PERIOD) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e) begin
        n_bad++; $display("FAIL midslot_scan: an/segs=%h/%h expected %h/%h", an, segs, e[11:8], e[7:0]);
      end
    end
  endtask

  task automatic test_disable();
    logic [11:0] e;
    int k;
    k = 0;
    while (an !== 4'b1011 && k < 60) begin @(negedge clk); k++; end
    n_cmp++;
    if (an !== 4'b1011) begin
      n_bad++; $display("FAIL disable_wait: an=%b never reached 1011", an);
    end
    bus_write(CTRL_ADDR, 32'h0000_0000);
    @(negedge clk);
    n_cmp++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      n_bad++; $display("FAIL disable_blank: an/segs=%h/%h expected F/FF", an, segs);
    end
    repeat (3) @(negedge clk);
    bus_write(CTRL_ADDR, 32'h0000_0001);
    @(negedge clk);
    n_cmp++;
    if (an !== 4'b1110 || segs !== 8'h21) begin
      n_bad++; $display("FAIL reenable_digit0: an/segs=%b/%h expected 1110/21", an, segs);
    end
    repeat (3 * PERIOD) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e) begin
        n_bad++; $display("FAIL reenable_scan: an/segs=%h/%h expected %h/%h", an, segs, e[11:8], e[7:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e;
    logic [31:0] a;
    logic [31:0] d;
    int sel;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e) begin
        n_bad++; $display("FAIL rand_scan[%0d]: an/segs=%h/%h expected %h/%h", i, an, segs, e[11:8], e[7:0]);
      end
      n_cmp++;
      if (iobus_in !== model_rd(iobus_addr)) begin
        n_bad++; $display("FAIL rand_rd[%0d]: addr=%h got %h expected %h", i, iobus_addr, iobus_in, model_rd(iobus_addr));
      end
      sel = $urandom_range(0, 11);
      if (sel == 0) begin
        d = $urandom;
        if ($urandom_range(0, 1) == 0) d[15:8] = 8'h00;
        bus_write(DATA_ADDR, d);
      end else if (sel == 1) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 5) != 0);
        bus_write(CTRL_ADDR, d);
      end else if (sel == 2) begin
        a = DATA_ADDR ^ (32'h1 << $urandom_range(0, 31));
        bus_write(a, $urandom);
      end else begin
        sel = $urandom_range(0, 2);
        iobus_addr = (sel == 0) ? DATA_ADDR : (sel == 1) ? CTRL_ADDR : $urandom;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    bus_write(DATA_ADDR, 32'h0000_5678);
    bus_write(CTRL_ADDR, 32'h0000_0001);
    repeat (PERIOD + 2) @(negedge clk);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      n_bad++; $display("FAIL async_rst_out: an/segs=%h/%h expected F/FF", an, segs);
    end
    iobus_addr = DATA_ADDR; #1;
    n_cmp++;
    if (iobus_in !== 32'h0) begin
      n_bad++; $display("FAIL async_rst_data: got %h expected 0", iobus_in);
    end
    iobus_addr = CTRL_ADDR; #1;
    n_cmp++;
    if (iobus_in !== 32'h0) begin
      n_bad++; $display("FAIL async_rst_ctrl: got %h expected 0", iobus_in);
    end
    @(negedge clk);
    RST_N = 1'b1;
    repeat (2 * PERIOD) begin
      @(negedge clk);
      e = model_out(m_run, m_t, snap_data, snap_lz);
      n_cmp++;
      if ({an, segs} !== e || an !== 4'hF) begin
        n_bad++; $display("FAIL post_rst_idle: an/segs=%h/%h expected F/FF", an, segs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_lz_blank();
    test_midslot_write();
    test_disable();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, clk cycles each digit is driven (minimum 2).
REQ-002 SHALL have parameter BLANK_CYC, default 500, clk cycles of inter-digit blanking (used only with SSEG_GHOST_BLANK_EN; minimum 1).
REQ-003 SHALL have parameter DATA_ADDR, default 32'h1100C010, address of the DATA register (bits 15:0 hex digits, bits 19:16 decimal points).
REQ-004 SHALL have parameter CTRL_ADDR, default 32'h1100C014, address of the CTRL register (bit0 ENABLE, bit1 LZ_BLANK).
REQ-005 clk  input  1  system clock; all state on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous, active-low.
REQ-007 iobus_addr  input  32  MCU I/O bus address.
REQ-008 iobus_out  input  32  MCU write data.
REQ-009 iobus_wr  input  1  MCU write strobe, one cycle per write.
REQ-010 iobus_in  output  32  readback data, zero unless the address matches.
REQ-011 segs  output  8  cathodes, active-low; bit0=a ... bit6=g, bit7=dp.
REQ-012 an  output  4  anodes, active-low; an[i] selects digit i (digit0 rightmost).

Function
REQ-013 SHALL write DATA[19:0] or CTRL[1:0] from iobus_out on the clk edge where iobus_wr=1 and iobus_addr matches; other addresses and bits SHALL be ignored.
REQ-014 SHALL drive iobus_in combinationally: {12'b0,DATA} at DATA_ADDR, {30'b0,CTRL} at CTRL_ADDR, otherwise 32'b0.
REQ-015 SHALL implement FSM states IDLE, SHOW, BLANK; in IDLE an=4'hF and segs=8'hFF.
REQ-016 IDLE->SHOW with digit index 0 and scan counter 0 on the first edge where ENABLE=1.
REQ-017 In SHOW the counter SHALL increment 0..SCAN_DIV-1; at SCAN_DIV-1 the index advances mod 4 (3 wraps to 0) and the counter clears.
REQ-018 Digit nibble, dp bit and blank decision SHALL be latched on entry to each digit slot; register writes SHALL NOT alter the digit currently shown.
REQ-019 On a simultaneous write and slot entry, the latch SHALL capture the pre-write register value.
REQ-020 Segment decode SHALL be full hex 0-F (e.g. 0 -> 8'b1100_0000 with dp off, F -> 8'b1000_1110); dp lit when DATA[16+i]=1.
REQ-021 With LZ_BLANK=1, digit i (i=3..1) SHALL be blank (an[i]=1, segs=8'hFF) when it and all higher digits are zero; digit0 SHALL never be blanked.
REQ-022 Exactly one an bit SHALL be low in SHOW for a non-blanked digit; no glitches (an and segs are registered).
REQ-023 ENABLE cleared while scanning SHALL return the FSM to IDLE on the next edge, outputs blank, counter and index cleared.

Reset
REQ-024 RST_N=0 SHALL immediately clear DATA, CTRL, counter and index, force IDLE, an=4'hF, segs=8'hFF, independent of clk.
REQ-025 Deassertion SHALL leave the block in IDLE until software sets ENABLE; reset mid-scan SHALL abort the current slot.

Configuration
REQ-026 With macro SSEG_GHOST_BLANK_EN defined, each SHOW slot end SHALL go to BLANK for BLANK_CYC cycles (an=4'hF, segs=8'hFF) before the next SHOW slot; period per digit = SCAN_DIV+BLANK_CYC.
REQ-027 Without SSEG_GHOST_BLANK_EN, BLANK SHALL be unreachable and SHOW slots SHALL be back-to-back; period per digit = SCAN_DIV.

Verification (SCAN_DIV=4, BLANK_CYC=2)
REQ-028 Reset, write DATA=0x0_1234, CTRL=0x1 -> an cycles 1110,1101,1011,0111 every 4 clks; segs 4,3,2,1 decoded; iobus_in=0x1234 at DATA_ADDR.
REQ-029 DATA=0x0_0007, CTRL=0x3 -> only an[0] ever low, segs=8'b1111_1000; digits 3..1 fully blank.
REQ-030 Write DATA=0xF_ABCD mid-slot of digit1 -> digit1 holds old value to slot end; next slots show new digits with dp lit.
REQ-031 Clear ENABLE during digit2 -> next edge an=4'hF, segs=8'hFF; re-enable restarts at digit0, counter 0.
REQ-032 RST_N low between clk edges during scan -> outputs blank immediately; DATA/CTRL read 0.
REQ-033 Build with SSEG_GHOST_BLANK_EN -> 2-cycle all-off gap between each digit, 6-cycle per-digit period; without it 4-cycle period, no gap.
